// File: rtl/data_memory_ctrl.sv
// Byte-addressed little-endian data memory for the MEM stage. Each access takes LATENCY edges
// and is signalled by a one-cycle done pulse; bad size, misalignment and out-of-range accesses finish early with err.
module data_memory_ctrl #(
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       data_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int NLANE = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [7:0]                  mem [DEPTH];
  logic                        mem_we;
  logic [NLANE-1:0]            byte_en;
  logic [NLANE-1:0][AW-1:0]    lane_idx;
  logic [NLANE-1:0][7:0]       rd_bytes;
  logic [31:0]                 ld_val;

  // request checks, evaluated on the incoming request in IDLE
  logic [1:0]        last_off;
  logic [ADDR_W:0]   end_addr;
  logic              req_bad;

  always_comb begin
    last_off = 2'd0;
    case (size_i)
      2'b01:   last_off = 2'd1;
      2'b10:   last_off = 2'd3;
      default: last_off = 2'd0;
    endcase
    end_addr = {1'b0, addr_i} + {{(ADDR_W - 1){1'b0}}, last_off};
    req_bad  = (size_i == 2'b11)
             || ((size_i == 2'b01) && addr_i[0])
             || ((size_i == 2'b10) && (addr_i[1:0] != 2'b00))
             || (end_addr >= (ADDR_W + 1)'(DEPTH));
  end

  always_comb begin
    byte_en = 4'b0001;
    case (size_q)
      2'b01:   byte_en = 4'b0011;
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0001;
    endcase
  end

  // one byte lane per possible byte of a word access; lane k addresses addr+k
  for (genvar k = 0; k < NLANE; k++) begin : g_lane
    assign lane_idx[k] = addr_q + AW'(k);
    assign rd_bytes[k] = byte_en[k] ? mem[lane_idx[k]] : 8'h00;
  end

  always_comb begin
    ld_val = rd_bytes;
    case (size_q)
      2'b00:   ld_val = uns_q ? {24'h0, rd_bytes[0]}
                              : {{24{rd_bytes[0][7]}}, rd_bytes[0]};
      2'b01:   ld_val = uns_q ? {16'h0, rd_bytes[1], rd_bytes[0]}
                              : {{16{rd_bytes[1][7]}}, rd_bytes[1], rd_bytes[0]};
      default: ld_val = rd_bytes;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          size_d  = size_i;
          uns_d   = unsigned_i;
          addr_d  = addr_i[AW-1:0];
          wdata_d = data_i;
          if (req_bad) begin
            state_d = ERR;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = DONE;
          if (we_q) mem_we = 1'b1;
          else      data_d = ld_val;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE) || (state_d == ERR);
    err_d  = (state_d == ERR);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // storage is deliberately not reset; a reset holds the FSM in IDLE so no write can fire
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < NLANE; k++) begin
        if (byte_en[k]) mem[lane_idx[k]] <= wdata_q[8*k +: 8];
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;
  assign data_o = data_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl (DEPTH=32, ADDR_W=32, LATENCY=2): directed
// vectors, held-request and mid-op reset cases, then model-driven random accesses.
module tb_data_memory_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        busy_o, done_o, err_o;
  logic [31:0] data_o;

  data_memory_ctrl #(.DEPTH(32), .ADDR_W(32), .LATENCY(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .addr_i(addr_i), .data_i(data_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .data_o(data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          ndone  = 0;
  logic [7:0]  mdl [32];
  logic [31:0] last_ld;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // completions are compared against the scoreboard away from the active edge
  always @(negedge clk_i) begin
    if (rst_i === 1'b1 && done_o === 1'b1) begin
      ndone++;
      if (sb_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("err", {31'd0, err_o}, {31'd0, e.err});
        chk("data", data_o, e.data);
      end
    end
  end

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data);
    we_i = we; size_i = sz; unsigned_i = uns; addr_i = addr; data_i = data;
  endtask

  task automatic op(input logic we, input logic [1:0] sz, input logic uns,
                    input logic [31:0] addr, input logic [31:0] data,
                    input logic exp_err, input logic [31:0] exp_data);
    exp_t e;
    int   n;
    e.err = exp_err; e.data = exp_data;
    sb_q.push_back(e);
    @(negedge clk_i);
    drive(we, sz, uns, addr, data);
    req_i = 1'b1;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    chk("busy_after_e0", {31'd0, busy_o}, 32'd1);
    n = 0;
    while (done_o !== 1'b1 && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("latency", n, exp_err ? 32'd0 : 32'd2);
    @(posedge clk_i); #1;
    chk("idle_after_done", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic mdl_calc(input logic we, input logic [1:0] sz, input logic uns,
                          input int addr, input logic [31:0] data,
                          output logic e, output logic [31:0] d);
    int nb;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e  = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0)
         || (addr + nb - 1 >= 32);
    d  = last_ld;
    if (!e) begin
      if (we) begin
        for (int k = 0; k < nb; k++) mdl[addr + k] = data[8*k +: 8];
      end else begin
        v = 32'd0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = mdl[addr + k];
        if (!uns && v[8*nb - 1]) begin
          for (int b = 8*nb; b < 32; b++) v[b] = 1'b1;
        end
        d = v;
        last_ld = v;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n0;
    logic        e;
    logic [31:0] d;
    rst_i = 1'b0; req_i = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_err",  {31'd0, err_o},  32'd0);
    chk("rst_data", data_o, 32'd0);
    @(negedge clk_i); rst_i = 1'b1;

    op(1'b1, 2'b10, 1'b0, 32'd8,  32'h8899AABB, 1'b0, 32'h0);
    op(1'b0, 2'b10, 1'b0, 32'd8,  32'h0, 1'b0, 32'h8899AABB);
    op(1'b0, 2'b01, 1'b0, 32'd10, 32'h0, 1'b0, 32'hFFFF8899);
    op(1'b0, 2'b01, 1'b1, 32'd10, 32'h0, 1'b0, 32'h00008899);
    op(1'b0, 2'b00, 1'b0, 32'd9,  32'h0, 1'b0, 32'hFFFFFFAA);
    op(1'b0, 2'b00, 1'b1, 32'd9,  32'h0, 1'b0, 32'h000000AA);
    op(1'b1, 2'b00, 1'b0, 32'd8,  32'hFFFFFF55, 1'b0, 32'h000000AA);
    op(1'b0, 2'b10, 1'b0, 32'd8,  32'h0, 1'b0, 32'h8899AA55);

    // rejected accesses: memory and data_o untouched
    op(1'b0, 2'b10, 1'b0, 32'd6,     32'h0, 1'b1, 32'h8899AA55);
    op(1'b0, 2'b01, 1'b0, 32'd9,     32'h0, 1'b1, 32'h8899AA55);
    op(1'b0, 2'b11, 1'b0, 32'd8,     32'h0, 1'b1, 32'h8899AA55);
    op(1'b0, 2'b10, 1'b0, 32'd30,    32'h0, 1'b1, 32'h8899AA55);
    op(1'b1, 2'b10, 1'b0, 32'h100,   32'h11111111, 1'b1, 32'h8899AA55);
    op(1'b1, 2'b10, 1'b0, 32'd6,     32'h22222222, 1'b1, 32'h8899AA55);
    op(1'b0, 2'b10, 1'b0, 32'd8,     32'h0, 1'b0, 32'h8899AA55);

    // top-of-memory boundary
    op(1'b1, 2'b10, 1'b0, 32'd28, 32'hDEADBEEF, 1'b0, 32'h8899AA55);
    op(1'b1, 2'b01, 1'b0, 32'd30, 32'hFFFF1234, 1'b0, 32'h8899AA55);
    op(1'b0, 2'b10, 1'b0, 32'd28, 32'h0, 1'b0, 32'h1234BEEF);
    op(1'b0, 2'b01, 1'b0, 32'd28, 32'h0, 1'b0, 32'hFFFFBEEF);
    op(1'b0, 2'b00, 1'b0, 32'd31, 32'h0, 1'b0, 32'h00000012);
    op(1'b0, 2'b00, 1'b0, 32'd32, 32'h0, 1'b1, 32'h00000012);

    // req held through BUSY: accepted at E0 and again at E4 only
    n0 = ndone;
    sb_q.push_back('{err: 1'b0, data: 32'h8899AA55});
    sb_q.push_back('{err: 1'b0, data: 32'h8899AA55});
    @(negedge clk_i);
    drive(1'b0, 2'b10, 1'b0, 32'd8, 32'h0);
    req_i = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      @(posedge clk_i); #1;
      if (i == 3) chk("held_idle_e3", {31'd0, busy_o}, 32'd0);
      if (i == 4) chk("held_busy_e4", {31'd0, busy_o}, 32'd1);
    end
    req_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #1;
    chk("held_done_count", ndone - n0, 32'd2);
    chk("held_sb_empty", sb_q.size(), 32'd0);

    // reset in BUSY aborts the store
    op(1'b1, 2'b10, 1'b0, 32'd0, 32'hCAFEF00D, 1'b0, 32'h8899AA55);
    @(negedge clk_i);
    drive(1'b1, 2'b10, 1'b0, 32'd0, 32'h12345678);
    req_i = 1'b1;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_rst_done", {31'd0, done_o}, 32'd0);
    chk("mid_rst_err",  {31'd0, err_o},  32'd0);
    chk("mid_rst_data", data_o, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    op(1'b0, 2'b10, 1'b0, 32'd0, 32'h0, 1'b0, 32'hCAFEF00D);

    // model-driven random traffic over a fully initialised memory
    last_ld = 32'hCAFEF00D;
    for (int w = 0; w < 8; w++) begin
      d = $urandom;
      mdl_calc(1'b1, 2'b10, 1'b0, w * 4, d, e, last_ld);
      op(1'b1, 2'b10, 1'b0, w * 4, d, 1'b0, 32'hCAFEF00D);
    end
    last_ld = 32'hCAFEF00D;
    for (int i = 0; i < 40; i++) begin
      logic        rwe, runs;
      logic [1:0]  rsz;
      int          ra;
      logic [31:0] rd;
      rwe  = ($urandom_range(0, 2) == 0);
      rsz  = 2'($urandom_range(0, 3));
      runs = 1'($urandom_range(0, 1));
      ra   = $urandom_range(0, 35);
      rd   = $urandom;
      mdl_calc(rwe, rsz, runs, ra, rd, e, d);
      op(rwe, rsz, runs, ra, rd, e, d);
    end

    repeat (4) @(posedge clk_i);
    #1;
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
